// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generation, combinational imem port and a DEPTH-entry
// {PC, Instr} prefetch queue. Optional zero-latency empty-queue bypass: IF_FETCH_BYPASS_EN.
module if_fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic                         clk,
  input  logic                         clr_PC,
  input  logic                         en_IF,
  input  logic [1:0]                   PCsrc,
  input  logic [ADDR_W-1:0]            PC_target_j,
  input  logic [ADDR_W-1:0]            PC_target_jr,
  input  logic [ADDR_W-1:0]            PC_target_branch,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [DATA_W-1:0]            imem_rdata,
  output logic                         out_valid,
  output logic [ADDR_W-1:0]            PC,
  output logic [DATA_W-1:0]            Instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic redirect, q_valid, q_deq, byp, byp_take, enq;
  logic [ADDR_W-1:0] target;

  always_comb begin
    redirect = (PCsrc != 2'b00);
    q_valid  = (count_q != '0);
`ifdef IF_FETCH_BYPASS_EN
    byp      = !q_valid && !redirect;
`else
    byp      = 1'b0;
`endif
    q_deq    = q_valid && en_IF;
    byp_take = byp && en_IF;
    // A bypassed instruction is consumed directly, so it must not also be queued.
    enq      = !redirect && !byp_take && ((count_q != FULL) || q_deq);
  end

  always_comb begin
    unique case (PCsrc)
      2'b01:   target = PC_target_j;
      2'b10:   target = PC_target_jr;
      2'b11:   target = PC_target_branch;
      default: target = fetch_pc_q;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      // Flush: any head consumed this cycle is younger than the redirect and is dropped.
      fetch_pc_d = target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (enq || byp_take) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (enq)             wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      if (q_deq)           rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      if (enq && !q_deq)   count_d    = count_q + CNT_W'(1);
      else if (!enq && q_deq) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr_PC) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !clr_PC) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    imem_addr = fetch_pc_q;
    count     = count_q;
    out_valid = q_valid || byp;
    PC        = '0;
    Instr     = '0;
    if (q_valid) begin
      PC    = pc_mem[rd_ptr_q];
      Instr = instr_mem[rd_ptr_q];
    end else if (byp) begin
      PC    = fetch_pc_q;
      Instr = imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue; imem model returns addr ^ 32'hA5A5_0000.
module tb_if_fetch_queue;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic              clk = 1'b0;
  logic              clr_PC = 1'b1;
  logic              en_IF = 1'b0;
  logic [1:0]        PCsrc = 2'b00;
  logic [ADDR_W-1:0] PC_target_j = '0;
  logic [ADDR_W-1:0] PC_target_jr = '0;
  logic [ADDR_W-1:0] PC_target_branch = '0;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic [ADDR_W-1:0] PC;
  logic [DATA_W-1:0] Instr;
  logic [CNT_W-1:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000), .PC_STEP(4)
  ) dut (
    .clk(clk), .clr_PC(clr_PC), .en_IF(en_IF), .PCsrc(PCsrc),
    .PC_target_j(PC_target_j), .PC_target_jr(PC_target_jr),
    .PC_target_branch(PC_target_branch), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .PC(PC),
    .Instr(Instr), .count(count)
  );

  always #5 clk = ~clk;

  always_comb imem_rdata = imem_addr ^ MASK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en);
    clr_PC = 1'b1;
    PCsrc  = 2'b00;
    en_IF  = en;
    step();
    step();
    clr_PC = 1'b0;
    #1;
  endtask

  task automatic fill3();
    en_IF = 1'b0;
    PCsrc = 2'b00;
    for (int k = 0; k < 8 && count != 3; k++) step();
    check("fill3_cnt", 64'(count), 3);
  endtask

  task automatic redir(input logic [1:0] sel, input logic [31:0] tgt);
    fill3();
    PC_target_j      = (sel == 2'b01) ? tgt : 32'hDEAD_0000;
    PC_target_jr     = (sel == 2'b10) ? tgt : 32'hDEAD_1000;
    PC_target_branch = (sel == 2'b11) ? tgt : 32'hDEAD_2000;
    PCsrc = sel;
    en_IF = 1'b1;
    step();
    check("redir_cnt", 64'(count), 0);
    check("redir_vld", 64'(out_valid), 0);
    check("redir_addr", 64'(imem_addr), 64'(tgt));
    PCsrc = 2'b00;
    step();
    check("redir_vld2", 64'(out_valid), 1);
    check("redir_pc", 64'(PC), 64'(tgt));
    check("redir_instr", 64'(Instr), 64'(tgt ^ MASK));
  endtask

  initial begin
    logic [31:0] exp_pc;
    int consumed;

`ifdef IF_FETCH_BYPASS_EN
    do_reset(1'b1);
    check("byp_vld0", 64'(out_valid), 1);
    check("byp_pc0", 64'(PC), 0);
    check("byp_instr0", 64'(Instr), 64'(MASK));
    check("byp_cnt0", 64'(count), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("byp_pc", 64'(PC), 64'(4 * i));
      check("byp_cnt", 64'(count), 0);
    end
    en_IF = 1'b0;
    step();
    check("byp_hold_cnt", 64'(count), 1);
    check("byp_hold_pc", 64'(PC), 16);
`else
    // Reset state and first-cycle latency
    do_reset(1'b1);
    check("rst_vld", 64'(out_valid), 0);
    check("rst_cnt", 64'(count), 0);
    check("rst_pc", 64'(PC), 0);
    check("rst_instr", 64'(Instr), 0);
    check("rst_addr", 64'(imem_addr), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("seq_vld", 64'(out_valid), 1);
      check("seq_pc", 64'(PC), 64'(4 * i));
      check("seq_instr", 64'(Instr), 64'(32'(4 * i) ^ MASK));
      check("seq_cnt", 64'(count), 1);
    end

    // Fill to full under stall, then drain at full rate
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("fill_cnt", 64'(count), 64'((i < 4) ? i : 4));
      check("fill_pc", 64'(PC), 0);
      check("fill_instr", 64'(Instr), 64'(MASK));
    end
    check("full_addr", 64'(imem_addr), 16);
    en_IF = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("drain_pc", 64'(PC), 64'(4 * i));
      check("drain_cnt", 64'(count), 4);
    end

    // Redirects flush the queue
    do_reset(1'b1);
    redir(2'b11, 32'h0000_0100);
    redir(2'b01, 32'h0000_0200);
    redir(2'b10, 32'h0000_0300);

    // Reset wins over a same-cycle redirect
    clr_PC = 1'b1;
    PCsrc = 2'b11;
    PC_target_branch = 32'h0000_0500;
    en_IF = 1'b1;
    step();
    check("rstredir_addr", 64'(imem_addr), 0);
    check("rstredir_cnt", 64'(count), 0);
    clr_PC = 1'b0;
    PCsrc = 2'b00;
    step();
    check("rstredir_pc", 64'(PC), 0);

    // Mid-stream reset
    fill3();
    clr_PC = 1'b1;
    step();
    check("midrst_cnt", 64'(count), 0);
    check("midrst_vld", 64'(out_valid), 0);
    clr_PC = 1'b0;

    // fetch_pc wraps modulo 2^ADDR_W
    en_IF = 1'b1;
    PC_target_j = 32'hFFFF_FFF8;
    PCsrc = 2'b01;
    step();
    check("wrapa_addr", 64'(imem_addr), 64'(32'hFFFF_FFF8));
    PCsrc = 2'b00;
    step();
    check("wrapa_pc0", 64'(PC), 64'(32'hFFFF_FFF8));
    step();
    check("wrapa_pc1", 64'(PC), 64'(32'hFFFF_FFFC));
    step();
    check("wrapa_pc2", 64'(PC), 0);
    check("wrapa_instr2", 64'(Instr), 64'(MASK));

    // Pointer wrap over 3*DEPTH entries with irregular consumption
    do_reset(1'b0);
    repeat (4) step();
    exp_pc = 32'h0;
    consumed = 0;
    for (int i = 0; i < 60 && consumed < 3 * DEPTH; i++) begin
      en_IF = (i % 3 != 2);
      if (en_IF && out_valid) begin
        check("fifo_pc", 64'(PC), 64'(exp_pc));
        check("fifo_instr", 64'(Instr), 64'(exp_pc ^ MASK));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      step();
    end
    check("fifo_consumed", 64'(consumed), 64'(3 * DEPTH));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage that replaces the single-PC fetch path. It generates sequential and redirected PCs, drives a combinational instruction-memory port, and buffers fetched {PC, instruction} pairs in a DEPTH-entry prefetch queue. The queue decouples fetch from ID-stage stalls. Sits between the PC-select logic (jump from ID, jr/branch from EX) and the IF/ID boundary.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  input  1  clock, rising edge
clr_PC  input  1  synchronous active-high reset
en_IF  input  1  ID ready; head entry consumed when out_valid && en_IF
PCsrc  input  2  00 sequential, 01 jump, 10 jr, 11 branch
PC_target_j  input  ADDR_W  jump target (from ID)
PC_target_jr  input  ADDR_W  jr target (from EX)
PC_target_branch  input  ADDR_W  branch target (from EX)
imem_addr  output  ADDR_W  = fetch_pc, combinational
imem_rdata  input  DATA_W  instruction at imem_addr, same cycle
out_valid  output  1  queue head valid
PC  output  ADDR_W  PC of head entry
Instr  output  DATA_W  instruction of head entry
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (clr_PC=1 at posedge): fetch_pc=RESET_PC; rd/wr pointers=0; count=0; out_valid=0. Reset overrides every other event, including a redirect in the same cycle.
- Empty queue: out_valid=0, PC=0, Instr=0 (NOP). These outputs are forced, not the stale contents of the RAM.
- deq = out_valid && en_IF.
- Redirect (PCsrc!=00, not in reset):
  - fetch_pc <= selected target.
  - Queue is flushed: pointers=0, count=0.
  - No enqueue occurs that cycle.
  - A deq in the same cycle is dropped. The head is younger than the redirecting instruction, so ID/EX must squash it.
- Sequential (PCsrc=00):
  - enq = (count<DEPTH) || deq.
  - On enq: write {fetch_pc, imem_rdata} at wr_ptr, advance wr_ptr, fetch_pc <= fetch_pc+PC_STEP.
  - When full without deq: hold fetch_pc and do not write.
- count update: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Pointers are log2(DEPTH) bits and wrap naturally. fetch_pc wraps modulo 2^ADDR_W.
- Stability: while out_valid && !en_IF with no redirect, PC and Instr hold constant.
- Latency: an instruction fetched in cycle N is visible at the head in cycle N+1 at the earliest. After reset deassert, the first out_valid=1 (PC=RESET_PC) comes one cycle later.
- Throughput: one instruction per cycle while en_IF=1, with no bubble at full or empty boundaries.
- PCsrc is sampled only when clr_PC=0. Values are treated as one-hot per cycle; no priority between targets is needed.

Optional Feature:
Macro: IF_FETCH_BYPASS_EN
- Defined:
  - When count==0 and PCsrc==00, out_valid=1 combinationally, with PC=fetch_pc and Instr=imem_rdata.
  - If en_IF=1, the instruction is consumed directly, nothing is enqueued, and fetch_pc advances.
  - If en_IF=0, the instruction is enqueued normally.
  - Result: zero-cycle fetch latency when the queue is empty.
- Undefined: empty queue always gives out_valid=0, with the 1-cycle latency above.

Test Plan:
- Memory model returns Instr=addr^32'hA5A5_0000. Hold clr_PC=1 for 2 cycles, release, en_IF=1, PCsrc=00 -> cycle after release: out_valid=1, PC=0x0; then PC=0x4, 0x8, 0xC on consecutive cycles, Instr matches the model, count stays at 1.
- en_IF=0 from release -> count goes 1,2,3,4, then holds at 4, fetch_pc=0x10, PC/Instr stable at 0x0. Then en_IF=1 -> PCs 0x0,0x4,0x8,0xC,0x10 back-to-back with no gap, count stays 4 while full.
- Queue holds 3 entries, PCsrc=11, PC_target_branch=0x100, en_IF=1 -> next cycle count=0, out_valid=0; following cycle PC=0x100. Repeat with 01 (target 0x200) and 10 (target 0x300).
- Redirect and clr_PC=1 in the same cycle -> fetch_pc=RESET_PC, not the target. Reset asserted mid-stream with count=3 -> count=0, out_valid=0 next cycle.
- PCsrc=01, PC_target_j=32'hFFFF_FFF8 -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. Run over 3*DEPTH entries so pointers wrap, with FIFO order preserved.
- With IF_FETCH_BYPASS_EN defined, en_IF=1 after reset -> out_valid=1, PC=0x0 in the first cycle after release, count=0 throughout. Without the macro, the same stimulus gives out_valid=0 in that cycle.
